// File: rtl/debug_chan_sequencer_pkg.sv
// debug_chan_sequencer_pkg
// Shared constants for the debug channel sequencer:
//   - mux geometry (number of channel codes, select width)
//   - default dwell counter width and guard length
//   - sequencer state encoding
//   - named debug mux channel codes
package debug_chan_sequencer_pkg;

    localparam int DEBUG_NUM_CHAN = 23;
    localparam int DEBUG_SEL_W    = 5;
    localparam int DEBUG_DWELL_W  = 16;
    localparam int DEBUG_GUARD    = 2;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FROZEN = 2'd2
    } seq_state_t;

    // Named debug mux sources
    localparam logic [DEBUG_SEL_W-1:0] DBG_CH_NRX = 5'd0;
    localparam logic [DEBUG_SEL_W-1:0] DBG_CH_SPI = 5'd11;

endpackage

// File: rtl/debug_chan_sequencer_if.sv
// debug_chan_sequencer_if
// Configuration, trigger and status bundle of the debug channel sequencer.
//   master : APB-side configuration/trigger source, observes mux status
//   slave  : the sequencer itself
// Signals:
//   cfg_chan_sel  static channel code     cfg_scan_en   1=scan, 0=static
//   cfg_chan_mask scan enable per channel cfg_dwell     dwell length minus 1
//   trig_arm      arm pulse               trig_in       freeze trigger level
//   chan_sel      mux select              debug_valid   mux output settled
//   frame_start   scan wrap pulse         armed/frozen  trigger status
//   switch_ts     (DEBUG_SEQ_TIMESTAMP_EN only) counter value at last scan switch
interface debug_chan_sequencer_if
    import debug_chan_sequencer_pkg::*;
#(
    parameter int NUM_CHAN = DEBUG_NUM_CHAN,
    parameter int SEL_W    = DEBUG_SEL_W,
    parameter int DWELL_W  = DEBUG_DWELL_W
);
    logic [SEL_W-1:0]    cfg_chan_sel;
    logic                cfg_scan_en;
    logic [NUM_CHAN-1:0] cfg_chan_mask;
    logic [DWELL_W-1:0]  cfg_dwell;
    logic                trig_arm;
    logic                trig_in;
    logic [SEL_W-1:0]    chan_sel;
    logic                debug_valid;
    logic                frame_start;
    logic                armed;
    logic                frozen;
`ifdef DEBUG_SEQ_TIMESTAMP_EN
    logic [15:0]         switch_ts;

    modport master (
        output cfg_chan_sel, cfg_scan_en, cfg_chan_mask, cfg_dwell, trig_arm, trig_in,
        input  chan_sel, debug_valid, frame_start, armed, frozen, switch_ts
    );
    modport slave (
        input  cfg_chan_sel, cfg_scan_en, cfg_chan_mask, cfg_dwell, trig_arm, trig_in,
        output chan_sel, debug_valid, frame_start, armed, frozen, switch_ts
    );
`else
    modport master (
        output cfg_chan_sel, cfg_scan_en, cfg_chan_mask, cfg_dwell, trig_arm, trig_in,
        input  chan_sel, debug_valid, frame_start, armed, frozen
    );
    modport slave (
        input  cfg_chan_sel, cfg_scan_en, cfg_chan_mask, cfg_dwell, trig_arm, trig_in,
        output chan_sel, debug_valid, frame_start, armed, frozen
    );
`endif
endinterface

// File: rtl/debug_chan_sequencer_next_chan.sv
// debug_next_chan
// Combinational circular priority finder over the scan enable mask.
//   mask   : channel enable mask
//   cur    : current channel code
//   next   : lowest set bit strictly above cur, else lowest set bit
//   lowest : lowest set bit of mask (0 when mask is empty)
//   any    : mask has at least one bit set
//   wrap   : no set bit above cur, so next wrapped to the lowest
module debug_next_chan
    import debug_chan_sequencer_pkg::*;
#(
    parameter int NUM_CHAN = DEBUG_NUM_CHAN,
    parameter int SEL_W    = DEBUG_SEL_W
) (
    input  logic [NUM_CHAN-1:0] mask,
    input  logic [SEL_W-1:0]    cur,
    output logic [SEL_W-1:0]    next,
    output logic [SEL_W-1:0]    lowest,
    output logic                any,
    output logic                wrap
);
    logic [NUM_CHAN-1:0] above;
    logic [SEL_W-1:0]    above_idx;
    logic                above_hit;

    for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_above
        assign above[gi] = mask[gi] && (gi > int'(cur));
    end

    // Scanning downward leaves the lowest hit in each result.
    always_comb begin
        lowest    = '0;
        above_idx = '0;
        above_hit = 1'b0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = SEL_W'(i);
            end
            if (above[i]) begin
                above_idx = SEL_W'(i);
                above_hit = 1'b1;
            end
        end
        any  = |mask;
        wrap = !above_hit;
        next = above_hit ? above_idx : lowest;
    end
endmodule

// File: rtl/debug_chan_sequencer.sv
// debug_chan_sequencer
// Drives the debug mux select from the PCLK domain. Static mode forwards the
// programmed channel; scan mode rotates through the enabled channels with a
// programmable dwell. debug_valid is held low for GUARD cycles after every
// select change or dwell restart; an armed trigger edge freezes the sequencer.
// Ports:
//   PCLK    : system clock
//   PRESETn : asynchronous active-low reset
//   bus     : configuration/trigger inputs and mux status (slave modport)
// Optional: define DEBUG_SEQ_TIMESTAMP_EN to add bus.switch_ts, a capture of a
// free-running 16-bit PCLK counter taken at every scan channel switch.
module debug_chan_sequencer
    import debug_chan_sequencer_pkg::*;
#(
    parameter int NUM_CHAN = DEBUG_NUM_CHAN,
    parameter int SEL_W    = DEBUG_SEL_W,
    parameter int DWELL_W  = DEBUG_DWELL_W,
    parameter int GUARD    = DEBUG_GUARD
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    debug_chan_sequencer_if.slave bus
);
    localparam int GUARD_W = ($clog2(GUARD + 1) < 1) ? 1 : $clog2(GUARD + 1);

    seq_state_t         state_reg, state_next;
    seq_state_t         prior_reg, prior_next;
    logic [SEL_W-1:0]   chan_sel_reg, chan_sel_next;
    logic [DWELL_W-1:0] dwell_reg, dwell_next;
    logic [GUARD_W-1:0] guard_reg, guard_next;
    logic               frame_reg, frame_next;
    logic               armed_reg, armed_next;
    logic               trig_q_reg;
    logic               trig_edge, freeze, restart;
    logic [SEL_W-1:0]   cfg_sel_mapped;
    logic [SEL_W-1:0]   nc_next, nc_lowest;
    logic               nc_any, nc_wrap;
`ifdef DEBUG_SEQ_TIMESTAMP_EN
    logic [15:0]        ts_cnt_reg;
    logic [15:0]        switch_ts_reg;
    logic               ts_capture;
`endif

    debug_next_chan #(
        .NUM_CHAN (NUM_CHAN),
        .SEL_W    (SEL_W)
    ) u_next_chan (
        .mask   (bus.cfg_chan_mask),
        .cur    (chan_sel_reg),
        .next   (nc_next),
        .lowest (nc_lowest),
        .any    (nc_any),
        .wrap   (nc_wrap)
    );

    // Out-of-range static codes select channel 0 rather than an undefined mux leg.
    assign cfg_sel_mapped = (int'(bus.cfg_chan_sel) < NUM_CHAN) ? bus.cfg_chan_sel : '0;
    assign trig_edge      = bus.trig_in & ~trig_q_reg;
    // An arm pulse in the same cycle as the edge re-arms instead of freezing.
    assign freeze         = armed_reg & trig_edge & ~bus.trig_arm;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg    <= ST_STATIC;
            prior_reg    <= ST_STATIC;
            chan_sel_reg <= '0;
            dwell_reg    <= '0;
            guard_reg    <= GUARD_W'(GUARD);
            frame_reg    <= 1'b0;
            armed_reg    <= 1'b0;
            trig_q_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            prior_reg    <= prior_next;
            chan_sel_reg <= chan_sel_next;
            dwell_reg    <= dwell_next;
            guard_reg    <= guard_next;
            frame_reg    <= frame_next;
            armed_reg    <= armed_next;
            trig_q_reg   <= bus.trig_in;
        end
    end

    always_comb begin
        state_next    = state_reg;
        prior_next    = prior_reg;
        chan_sel_next = chan_sel_reg;
        dwell_next    = dwell_reg;
        frame_next    = 1'b0;
        armed_next    = armed_reg;
        restart       = 1'b0;
`ifdef DEBUG_SEQ_TIMESTAMP_EN
        ts_capture    = 1'b0;
`endif
        // While frozen, an arm pulse is consumed by the unfreeze and does not re-arm.
        if (bus.trig_arm && state_reg != ST_FROZEN) begin
            armed_next = 1'b1;
        end

        case (state_reg)
            ST_STATIC: begin
                if (freeze) begin
                    state_next = ST_FROZEN;
                    prior_next = ST_STATIC;
                    armed_next = 1'b0;
                end else if (bus.cfg_scan_en && nc_any) begin
                    state_next    = ST_SCAN;
                    chan_sel_next = nc_lowest;
                    frame_next    = 1'b1;
                    dwell_next    = '0;
                    restart       = 1'b1;
                end else begin
                    chan_sel_next = cfg_sel_mapped;
                end
            end
            ST_SCAN: begin
                if (freeze) begin
                    state_next = ST_FROZEN;
                    prior_next = ST_SCAN;
                    armed_next = 1'b0;
                end else if (!bus.cfg_scan_en || !nc_any) begin
                    state_next    = ST_STATIC;
                    chan_sel_next = cfg_sel_mapped;
                end else if (dwell_reg >= bus.cfg_dwell) begin
                    // >= so that shrinking cfg_dwell mid-dwell ends the dwell at once
                    chan_sel_next = nc_next;
                    dwell_next    = '0;
                    frame_next    = nc_wrap;
                    restart       = 1'b1;
`ifdef DEBUG_SEQ_TIMESTAMP_EN
                    ts_capture    = 1'b1;
`endif
                end else begin
                    dwell_next = dwell_reg + 1'b1;
                end
            end
            ST_FROZEN: begin
                if (bus.trig_arm) begin
                    state_next = prior_reg;
                    dwell_next = '0;
                    restart    = 1'b1;
                end
            end
            default: begin
                state_next = ST_STATIC;
            end
        endcase

        if (restart || (chan_sel_next != chan_sel_reg)) begin
            guard_next = GUARD_W'(GUARD);
        end else if (guard_reg != '0) begin
            guard_next = guard_reg - 1'b1;
        end else begin
            guard_next = guard_reg;
        end
    end

`ifdef DEBUG_SEQ_TIMESTAMP_EN
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ts_cnt_reg    <= '0;
            switch_ts_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + 1'b1;
            if (ts_capture) begin
                switch_ts_reg <= ts_cnt_reg;
            end
        end
    end

    assign bus.switch_ts = switch_ts_reg;
`endif

    assign bus.chan_sel    = chan_sel_reg;
    assign bus.debug_valid = (guard_reg == '0);
    assign bus.frame_start = frame_reg;
    assign bus.armed       = armed_reg;
    assign bus.frozen      = (state_reg == ST_FROZEN);
endmodule

// File: tb/tb_debug_chan_sequencer.sv
// tb_debug_chan_sequencer
// Directed stimulus with literal expectations, plus a cycle-level reference
// model of the sequencer rules compared against the DUT on every falling edge.
// Covers DEBUG_SEQ_TIMESTAMP_EN when that macro is defined for the build.
module tb_debug_chan_sequencer;
    import debug_chan_sequencer_pkg::*;

    localparam int NCH = 23;
    localparam int GRD = 2;

    logic PCLK;
    logic PRESETn;
    int   n_checks = 0;
    int   n_errors = 0;

    debug_chan_sequencer_if bus ();

    debug_chan_sequencer dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // ---------------- reference model ----------------
    // mode: 0 static, 1 scan, 2 frozen
    int m_mode, m_prior, m_sel, m_dwell, m_age, m_ts, m_switch_ts;
    bit m_frame, m_armed, m_trig_q;

    // Next enabled channel strictly above cur, wrapping to the lowest enabled one.
    function automatic int scan_next(input logic [NCH-1:0] mask, input int cur, output bit wrapped);
        for (int i = cur + 1; i < NCH; i++) begin
            if (mask[i]) begin
                wrapped = 1'b0;
                return i;
            end
        end
        wrapped = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prior = 0; m_sel = 0; m_dwell = 0; m_age = 0;
        m_frame = 0; m_armed = 0; m_trig_q = 0; m_ts = 0; m_switch_ts = 0;
    endtask

    // Advance the model by one PCLK edge using the inputs about to be sampled.
    task automatic model_step();
        int  newsel, cfgmap;
        bit  edge_seen, restart, w;
        edge_seen = bus.trig_in && !m_trig_q;
        m_trig_q  = bus.trig_in;
        cfgmap    = (int'(bus.cfg_chan_sel) < NCH) ? int'(bus.cfg_chan_sel) : 0;
        newsel    = m_sel;
        restart   = 0;
        m_frame   = 0;
        if (m_mode == 2) begin
            if (bus.trig_arm) begin
                m_mode = m_prior; m_dwell = 0; restart = 1;
            end
        end else if (m_armed && edge_seen && !bus.trig_arm) begin
            m_prior = m_mode; m_mode = 2; m_armed = 0;
        end else begin
            if (bus.trig_arm) m_armed = 1;
            if (m_mode == 0) begin
                if (bus.cfg_scan_en && bus.cfg_chan_mask != 0) begin
                    m_mode = 1; newsel = scan_next(bus.cfg_chan_mask, -1, w);
                    m_frame = 1; m_dwell = 0; restart = 1;
                end else begin
                    newsel = cfgmap;
                end
            end else begin
                if (!bus.cfg_scan_en || bus.cfg_chan_mask == 0) begin
                    m_mode = 0; newsel = cfgmap;
                end else if (m_dwell >= int'(bus.cfg_dwell)) begin
                    newsel = scan_next(bus.cfg_chan_mask, m_sel, w);
                    m_frame = w; m_dwell = 0; restart = 1;
                    m_switch_ts = m_ts;
                end else begin
                    m_dwell++;
                end
            end
        end
        if (restart || newsel != m_sel) m_age = 0;
        else if (m_age < GRD) m_age++;
        m_sel = newsel;
        m_ts  = (m_ts + 1) % 65536;
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        model_reset();
        forever begin
            @(negedge PCLK);
            if (!PRESETn) model_reset();
            chk("model chan_sel", int'(bus.chan_sel), m_sel);
            chk("model debug_valid", int'(bus.debug_valid), int'(m_age >= GRD));
            chk("model frame_start", int'(bus.frame_start), int'(m_frame));
            chk("model armed", int'(bus.armed), int'(m_armed));
            chk("model frozen", int'(bus.frozen), int'(m_mode == 2));
`ifdef DEBUG_SEQ_TIMESTAMP_EN
            chk("model switch_ts", int'(bus.switch_ts), m_switch_ts);
`endif
            if (PRESETn) model_step();
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int guard_loop;
        PRESETn = 1'b0;
        bus.cfg_chan_sel  = '0;
        bus.cfg_scan_en   = 1'b0;
        bus.cfg_chan_mask = '0;
        bus.cfg_dwell     = '0;
        bus.trig_arm      = 1'b0;
        bus.trig_in       = 1'b0;
        tick(2);
        chk("reset chan_sel", int'(bus.chan_sel), 0);
        chk("reset debug_valid", int'(bus.debug_valid), 0);
        chk("reset frame_start", int'(bus.frame_start), 0);
        chk("reset armed", int'(bus.armed), 0);
        chk("reset frozen", int'(bus.frozen), 0);
        PRESETn = 1'b1;

        // Static mode
        tick(3);
        bus.cfg_chan_sel = 5'd9;
        tick(1);
        chk("static sel 9", int'(bus.chan_sel), 9);
        chk("static guard t0", int'(bus.debug_valid), 0);
        tick(1);
        chk("static guard t1", int'(bus.debug_valid), 0);
        tick(1);
        chk("static valid t2", int'(bus.debug_valid), 1);
        bus.cfg_chan_sel = 5'd30;
        tick(1);
        chk("static sel 30->0", int'(bus.chan_sel), 0);

        // Scan order: channels 0,2,3 with dwell 3
        bus.cfg_chan_mask = 23'h00000D;
        bus.cfg_dwell     = 16'd3;
        bus.cfg_scan_en   = 1'b1;
        tick(1);
        chk("scan entry sel", int'(bus.chan_sel), 0);
        chk("scan entry frame", int'(bus.frame_start), 1);
        chk("scan entry guard", int'(bus.debug_valid), 0);
        tick(2);
        chk("scan ch0 valid", int'(bus.debug_valid), 1);
        tick(2);
        chk("scan sel 2", int'(bus.chan_sel), 2);
        chk("scan sel 2 frame", int'(bus.frame_start), 0);
        chk("scan sel 2 guard", int'(bus.debug_valid), 0);
        tick(4);
        chk("scan sel 3", int'(bus.chan_sel), 3);
        tick(4);
        chk("scan wrap sel 0", int'(bus.chan_sel), 0);
        chk("scan wrap frame", int'(bus.frame_start), 1);

        // Single-bit mask, then empty mask
        bus.cfg_chan_mask = 23'h000400;
        bus.cfg_dwell     = 16'd1;
        tick(2);
        chk("single sel 10", int'(bus.chan_sel), 10);
        chk("single first frame", int'(bus.frame_start), 0);
        tick(2);
        chk("single frame a", int'(bus.frame_start), 1);
        chk("single sel held", int'(bus.chan_sel), 10);
        tick(1);
        chk("single frame gap", int'(bus.frame_start), 0);
        tick(1);
        chk("single frame b", int'(bus.frame_start), 1);
        bus.cfg_chan_sel  = DBG_CH_SPI;
        bus.cfg_chan_mask = '0;
        tick(1);
        chk("empty mask static sel", int'(bus.chan_sel), 11);
        chk("empty mask frame", int'(bus.frame_start), 0);

        // Trigger freeze and resume
        bus.cfg_chan_mask = 23'h0000FF;
        bus.cfg_dwell     = 16'd7;
        tick(1);
        chk("trig scan entry", int'(bus.chan_sel), 0);
        bus.trig_arm = 1'b1;
        tick(1);
        bus.trig_arm = 1'b0;
        chk("trig armed", int'(bus.armed), 1);
        guard_loop = 0;
        while (bus.chan_sel != 5'd5 && guard_loop < 80) begin
            tick(1);
            guard_loop++;
        end
        chk("trig reached ch5", int'(bus.chan_sel), 5);
        bus.trig_in = 1'b1;
        tick(1);
        chk("trig frozen", int'(bus.frozen), 1);
        chk("trig disarmed", int'(bus.armed), 0);
        bus.cfg_scan_en  = 1'b0;
        bus.cfg_chan_sel = 5'd3;
        tick(100);
        chk("frozen hold sel", int'(bus.chan_sel), 5);
        chk("frozen stays", int'(bus.frozen), 1);
        chk("frozen valid", int'(bus.debug_valid), 1);
        bus.cfg_scan_en = 1'b1;
        bus.trig_in     = 1'b0;
        bus.trig_arm    = 1'b1;
        tick(1);
        bus.trig_arm = 1'b0;
        chk("resume unfrozen", int'(bus.frozen), 0);
        chk("resume guard", int'(bus.debug_valid), 0);
        tick(7);
        chk("resume dwell sel 5", int'(bus.chan_sel), 5);
        tick(1);
        chk("resume sel 6", int'(bus.chan_sel), 6);

        // Arm and trigger edge in the same cycle
        bus.trig_arm = 1'b1;
        tick(1);
        bus.trig_arm = 1'b0;
        chk("rearm armed", int'(bus.armed), 1);
        bus.trig_arm = 1'b1;
        bus.trig_in  = 1'b1;
        tick(1);
        bus.trig_arm = 1'b0;
        chk("arm wins frozen", int'(bus.frozen), 0);
        chk("arm wins armed", int'(bus.armed), 1);
        tick(1);
        chk("level no refreeze", int'(bus.frozen), 0);

        // Asynchronous reset mid-scan
        guard_loop = 0;
        while (bus.chan_sel == 5'd0 && guard_loop < 20) begin
            tick(1);
            guard_loop++;
        end
        #2;
        PRESETn = 1'b0;
        #1;
        chk("async rst chan_sel", int'(bus.chan_sel), 0);
        chk("async rst valid", int'(bus.debug_valid), 0);
        chk("async rst armed", int'(bus.armed), 0);
        chk("async rst frozen", int'(bus.frozen), 0);
        chk("async rst frame", int'(bus.frame_start), 0);
        tick(2);
        PRESETn     = 1'b1;
        bus.trig_in = 1'b0;
        tick(1);
        chk("post rst entry frame", int'(bus.frame_start), 1);
        chk("post rst armed", int'(bus.armed), 0);

        // Zero dwell: advance every cycle, valid never rises
        bus.cfg_chan_mask = 23'h00000D;
        bus.cfg_dwell     = 16'd0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("dwell0 valid low", int'(bus.debug_valid), 0);
        end

`ifdef DEBUG_SEQ_TIMESTAMP_EN
        // Timestamps: dwell 9 gives switches 10 cycles apart, across the counter wrap
        begin
            int last_ts;
            bus.cfg_dwell = 16'd9;
            tick(12);
            last_ts = int'(bus.switch_ts);
            for (int k = 0; k < 6700; k++) begin
                tick(10);
                chk("switch_ts delta", (int'(bus.switch_ts) - last_ts + 65536) % 65536, 10);
                last_ts = int'(bus.switch_ts);
            end
        end
`endif

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
